// File: rtl/drum_step_scheduler.sv
// Four-instrument step sequencer: loads patterns and tempo via a go-driven
// mode FSM, then plays 8-step patterns, emitting trigger pulses aligned to
// the audio sample strobe.
module drum_step_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] sel,
  input  logic       beat_tick,
  input  logic       sample_tick,
  output logic [7:0] ins1_pat,
  output logic [7:0] ins2_pat,
  output logic [7:0] ins3_pat,
  output logic [7:0] ins4_pat,
  output logic [7:0] bpm,
  output logic [2:0] step,
  output logic [3:0] trig,
  output logic       play,
  output logic [2:0] mode,
  output logic       dropped
);

  localparam int unsigned PAT_W   = 8;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned NUM_INS = 4;
  localparam int unsigned MODE_W  = 3;

  typedef enum logic [MODE_W-1:0] {
    S_LD1  = 3'd0,
    S_LD2  = 3'd1,
    S_LD3  = 3'd2,
    S_LD4  = 3'd3,
    S_BPM  = 3'd4,
    S_PLAY = 3'd5
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                go_q;
  logic                go_edge_c;
  logic                in_play_c;
  logic                enter_play_c;
  logic                fire_c;
  logic [STEP_W-1:0]   step_inc_c;
  logic [NUM_INS-1:0]  beat_bits_c;
  logic [NUM_INS-1:0]  pending;

  assign go_edge_c    = go & ~go_q;
  assign in_play_c    = (state == S_PLAY);
  assign enter_play_c = (state == S_BPM) & go_edge_c;
  assign step_inc_c   = step + STEP_W'(1);
  // Bit (7-n) of each pattern plays on step n; ~n equals 7-n for a 3-bit index.
  assign beat_bits_c  = {ins4_pat[~step_inc_c], ins3_pat[~step_inc_c],
                         ins2_pat[~step_inc_c], ins1_pat[~step_inc_c]};
  // A sample strobe fires only when no beat or mode change claims this cycle.
  assign fire_c       = in_play_c & ~go_edge_c & ~beat_tick & sample_tick & (|pending);
  assign mode         = MODE_W'(state);

  // Previous-cycle go; resets high so go held through reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) go_q <= 1'b1;
    else        go_q <= go;
  end

  // Mode state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LD1;
    else        state <= state_next;
  end

  // Next-state logic: advance one mode per go edge; illegal codes recover.
  always_comb begin
    state_next = state;
    case (state)
      S_LD1:   if (go_edge_c) state_next = S_LD2;
      S_LD2:   if (go_edge_c) state_next = S_LD3;
      S_LD3:   if (go_edge_c) state_next = S_LD4;
      S_LD4:   if (go_edge_c) state_next = S_BPM;
      S_BPM:   if (go_edge_c) state_next = S_PLAY;
      S_PLAY:  if (go_edge_c) state_next = S_LD1;
      default: state_next = S_LD1;
    endcase
  end

  // Play indicator tracks the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) play <= 1'b0;
    else        play <= (state_next == S_PLAY);
  end

  // Pattern and tempo capture on the go edge that leaves each load mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ins1_pat <= '0;
      ins2_pat <= '0;
      ins3_pat <= '0;
      ins4_pat <= '0;
      bpm      <= PAT_W'(120);
    end else if (go_edge_c) begin
      case (state)
        S_LD1:   ins1_pat <= sel;
        S_LD2:   ins2_pat <= sel;
        S_LD3:   ins3_pat <= sel;
        S_LD4:   ins4_pat <= sel;
        S_BPM:   bpm      <= (sel == '0) ? PAT_W'(1) : sel;
        default: ;
      endcase
    end
  end

  // Step pointer, pending triggers and overwrite flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step    <= '0;
      pending <= '0;
      dropped <= 1'b0;
    end else if (!in_play_c) begin
      pending <= '0;
      step    <= enter_play_c ? STEP_W'(7) : STEP_W'(0);
    end else if (go_edge_c) begin
      pending <= '0;
      step    <= '0;
    end else if (beat_tick) begin
      step    <= step_inc_c;
      pending <= beat_bits_c;
      if (|pending) dropped <= 1'b1;
    end else if (fire_c) begin
      pending <= '0;
    end
  end

  // One-cycle trigger pulse released on the sample strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) trig <= '0;
    else        trig <= fire_c ? pending : '0;
  end

endmodule

// File: tb/tb_drum_step_scheduler.sv
// Scoreboard bench for drum_step_scheduler: a mode/pattern reference model
// predicts register state and trigger pulses; a monitor matches pulses.
module tb_drum_step_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [7:0] sel;
  logic       beat_tick;
  logic       sample_tick;
  logic [7:0] ins1_pat, ins2_pat, ins3_pat, ins4_pat, bpm;
  logic [2:0] step;
  logic [3:0] trig;
  logic       play;
  logic [2:0] mode;
  logic       dropped;

  drum_step_scheduler dut (
    .clk(clk), .reset(reset), .go(go), .sel(sel), .beat_tick(beat_tick),
    .sample_tick(sample_tick), .ins1_pat(ins1_pat), .ins2_pat(ins2_pat),
    .ins3_pat(ins3_pat), .ins4_pat(ins4_pat), .bpm(bpm), .step(step),
    .trig(trig), .play(play), .mode(mode), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  typedef struct { logic [3:0] val; int at; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // Reference model
  int         m_mode;
  int         m_step;
  logic [7:0] m_pat [4];
  logic [7:0] m_bpm;
  logic [3:0] m_pend;
  logic       m_drop;
  logic       m_gp;

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_bpm = 8'd120; m_pend = 4'd0; m_drop = 1'b0; m_gp = 1'b1;
    for (int k = 0; k < 4; k++) m_pat[k] = 8'h00;
  endtask

  task automatic model_step(input logic g, input logic [7:0] s, input logic b, input logic sm);
    logic edge_seen;
    edge_seen = g && !m_gp;
    m_gp = g;
    if (m_mode == 5 && !edge_seen) begin
      if (b) begin
        if (m_pend != 4'd0) m_drop = 1'b1;
        m_step = (m_step + 1) % 8;
        for (int k = 0; k < 4; k++) m_pend[k] = m_pat[k][7 - m_step];
      end else if (sm && m_pend != 4'd0) begin
        exp_q.push_back('{val: m_pend, at: cyc + 1});
        m_pend = 4'd0;
      end
    end
    if (edge_seen) begin
      if (m_mode <= 3) begin
        m_pat[m_mode] = s;
        m_mode = m_mode + 1;
      end else if (m_mode == 4) begin
        m_bpm = (s == 8'd0) ? 8'd1 : s;
        m_mode = 5; m_step = 7; m_pend = 4'd0;
      end else begin
        m_mode = 0; m_step = 0; m_pend = 4'd0;
      end
    end
  endtask

  task automatic check_state(input string name);
    logic [47:0] act, expv;
    act  = {mode, play, step, ins1_pat, ins2_pat, ins3_pat, ins4_pat, bpm, dropped};
    expv = {3'(m_mode), (m_mode == 5), 3'(m_step), m_pat[0], m_pat[1], m_pat[2], m_pat[3],
            m_bpm, m_drop};
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h (mode,play,step,pats,bpm,dropped)",
               name, cyc, act, expv);
    end
  endtask

  task automatic check_reset(input string name);
    logic [51:0] act, expv;
    act  = {mode, play, step, ins1_pat, ins2_pat, ins3_pat, ins4_pat, bpm, dropped, trig};
    expv = {3'd0, 1'b0, 3'd0, 32'h0, 8'd120, 1'b0, 4'd0};
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, expv);
    end
  endtask

  task automatic tick(input logic g, input logic [7:0] s, input logic b, input logic sm,
                      input string name);
    go = g; sel = s; beat_tick = b; sample_tick = sm;
    model_step(g, s, b, sm);
    @(posedge clk);
    #1;
    check_state(name);
  endtask

  task automatic pulse_go(input logic [7:0] s);
    tick(1'b1, s, 1'b0, 1'b0, "load_edge");
    tick(1'b0, s, 1'b0, 1'b0, "load_idle");
  endtask

  task automatic load_all(input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3,
                          input logic [7:0] p4, input logic [7:0] b);
    for (int i = 0; i < 6 && m_mode != 0; i++) pulse_go(8'h00);
    pulse_go(p1); pulse_go(p2); pulse_go(p3); pulse_go(p4); pulse_go(b);
  endtask

  task automatic do_reset(input string name);
    #2 reset = 1'b0;
    #1 check_reset(name);
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_state({name, "_release"});
  endtask

  // Trigger monitor: every pulse, and every due prediction, is matched in order.
  always @(negedge clk) begin
    if (reset && (trig != 4'd0 || (exp_q.size() > 0 && exp_q[0].at <= cyc))) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL trig_unexpected cyc=%0d got=%h want=0", cyc, trig);
      end else begin
        e = exp_q.pop_front();
        if (trig !== e.val || cyc != e.at) begin
          failures++;
          $display("FAIL trig_match got=%h@%0d want=%h@%0d", trig, cyc, e.val, e.at);
        end else if (trig[0]) begin
          pulses++;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; go = 1'b1; sel = 8'h00; beat_tick = 1'b0; sample_tick = 1'b0;
    model_reset();
    #2 reset = 1'b0;
    #1 check_reset("reset_values");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // go held high across reset release is not an edge
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h55, 1'b0, 1'b0, "go_held_no_edge");
    tick(1'b0, 8'h00, 1'b0, 1'b0, "go_low");

    // Basic load sequence
    load_all(8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h90);
    tick(1'b0, 8'h00, 1'b0, 1'b0, "loaded_play");

    // MSB-first playback with a 1041-cycle sample strobe, bpm sel=0 -> 1
    load_all(8'h81, 8'h00, 8'h00, 8'h00, 8'h00);
    pulses = 0;
    for (int c = 0; c < 10800; c++)
      tick(1'b0, 8'h00, (c % 1200) == 5, (c % 1041) == 1040, "play_81");
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL play_81_pulses got=%0d want=3", pulses);
    end

    // beat and sample together: beat wins, trigger waits for the next strobe
    load_all(8'h00, 8'h00, 8'h00, 8'hFF, 8'd50);
    tick(1'b0, 8'h00, 1'b1, 1'b1, "beat_sample_same");
    tick(1'b0, 8'h00, 1'b0, 1'b0, "beat_sample_idle");
    tick(1'b0, 8'h00, 1'b0, 1'b1, "beat_sample_fire");
    tick(1'b0, 8'h00, 1'b0, 1'b0, "beat_sample_after");

    // Two beats with no strobe: overwrite sets dropped, one pulse follows
    tick(1'b0, 8'h00, 1'b1, 1'b0, "drop_beat1");
    tick(1'b0, 8'h00, 1'b1, 1'b0, "drop_beat2");
    tick(1'b0, 8'h00, 1'b0, 1'b0, "drop_idle");
    tick(1'b0, 8'h00, 1'b0, 1'b1, "drop_fire");
    tick(1'b0, 8'h00, 1'b0, 1'b1, "drop_after");

    // Reset while a trigger is pending: no pulse, reset values
    tick(1'b0, 8'h00, 1'b1, 1'b0, "pend_beat");
    tick(1'b0, 8'h00, 1'b0, 1'b0, "pend_idle");
    do_reset("reset_pending");
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0, 1'b1, "after_reset");

    // Randomized playback and mode traffic
    load_all(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 199) == 0, 8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 4) == 0, "random");
    go = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0, 1'b1, "flush");
    tick(1'b0, 8'h00, 1'b0, 1'b0, "flush_idle");
    tick(1'b0, 8'h00, 1'b0, 1'b0, "flush_idle");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL trig_outstanding got=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drum_step_scheduler.md
DRUM_STEP_SCHEDULER -- requirements
Module: drum_step_scheduler

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be, in order:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous active-low reset
- go  in  1  synchronous level, active-high; rising edge advances the mode FSM
- sel  in  8  pattern/BPM value from switches
- beat_tick  in  1  one-clk pulse per sequencer step, from the BPM generator
- sample_tick  in  1  one-clk 48 kHz strobe
- ins1_pat, ins2_pat, ins3_pat, ins4_pat  out  8 each  stored patterns
- bpm  out  8  stored tempo
- step  out  3  current step index
- trig  out  4  one-clk trigger pulses; bit k-1 drives instrument k
- play  out  1  high in S_PLAY
- mode  out  3  state code
- dropped  out  1  sticky flag: a trigger was overwritten before firing

Function
REQ-003 FSM states and mode codes SHALL be: S_LD1=0, S_LD2=1, S_LD3=2, S_LD4=3, S_BPM=4, S_PLAY=5; codes 6-7 SHALL be unreachable and SHALL recover to S_LD1 on the next clk.
REQ-004 A go edge SHALL be go=1 with previous-cycle go=0; the edge register SHALL reset to 1, so go held through reset release produces no edge.
REQ-005 Transitions SHALL occur only on a go edge: S_LD1->S_LD2->S_LD3->S_LD4->S_BPM->S_PLAY->S_LD1.
REQ-006 On a go edge in S_LDk, sel SHALL be latched into insk_pat in the same clk that the state advances; outside that clk, pattern registers SHALL hold.
REQ-007 On a go edge in S_BPM, bpm SHALL latch sel; sel=0 SHALL store 8'd1.
REQ-008 play SHALL be 1 exactly while in S_PLAY; mode SHALL equal the current state code.
REQ-009 On entry to S_PLAY, the internal step pointer SHALL be set to 7, so the first beat_tick selects step 0.
REQ-010 In S_PLAY, each beat_tick SHALL advance step by 1 modulo 8 (7->0 wrap) in the next clk.
REQ-011 The pattern bit for step n SHALL be bit (7-n), so the MSB plays first.
REQ-012 On beat_tick in S_PLAY, pending[k-1] SHALL load insk_pat[7-newstep] for all k at once, one clk after beat_tick.
REQ-013 On the first clk with sample_tick=1 and pending!=0, trig SHALL be registered to pending for exactly one clk (next clk), and pending SHALL clear.
REQ-014 If beat_tick and sample_tick are high in the same clk, beat_tick SHALL take precedence: pending loads and that sample_tick SHALL NOT fire.
REQ-015 If beat_tick arrives while pending!=0, pending SHALL be overwritten and dropped SHALL set to 1 until reset.
REQ-016 Outside S_PLAY, beat_tick SHALL be ignored, trig SHALL be 0, and pending SHALL be 0.
REQ-017 Leaving S_PLAY SHALL clear pending in the same clk, so no trig pulse is issued after play falls; step SHALL go to 0.
REQ-018 Maximum trig latency SHALL be 2 clk after beat_tick plus the wait for the next sample_tick (at most one sample period).

Reset
REQ-019 On reset=0, all of the following SHALL be set immediately, independent of clk:
- mode = S_LD1
- all patterns = 8'h00
- bpm = 8'd120
- step = 0, pending = 0, trig = 0
- play = 0, dropped = 0
REQ-020 Reset asserted mid-S_PLAY SHALL abort any pending trigger with no trig pulse emitted.

Verification
REQ-021 Load sequence: sel=A5,3C,FF,01,90 with five go edges -> ins1..4_pat = A5,3C,FF,01, bpm=90, mode=5, play=1.
REQ-022 Play ins1=8'b1000_0001, others 0, then 8 beat_ticks with sample_tick every 1041 clk:
- trig[0] pulses on steps 0 and 7 only
- step sequence reads 0..7, then wraps to 0 on the 9th tick
REQ-023 beat_tick and sample_tick in the same clk -> no trig that cycle; trig fires on the next sample_tick.
REQ-024 Two beat_ticks with no sample_tick between them, ins4_pat=FF -> dropped=1, single trig[3] pulse.
REQ-025 go held high across reset release -> mode stays 0; sel=0 in S_BPM -> bpm=1.
REQ-026 Reset pulse while pending!=0 in S_PLAY -> trig never asserts, all outputs at reset values.
